seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side decoder for the team's multiplexed 8-digit 7-segment bus (enable[7:0] + segs[6:0], both active-low).
//  Samples the strobed digits, decodes each segment pattern back to a hex nibble and reassembles the 32-bit word.
//  Used as an on-board loopback monitor or a second board reading the display bus; pulses value_vld per complete frame.
// PARAMETERS
//  STABLE_CNT  4   cycles an (enable,segs) pair must hold unchanged before capture; legal range 1..255
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-low
//  enable     in   8   digit strobe, active-low one-hot; bit i low = digit i (nibble [4i+3:4i]) driven
//  segs       in   7   segment pattern {a,b,c,d,e,f,g}, active-low
//  value      out  32  last complete decoded word
//  value_vld  out  1   one-cycle pulse when value updates
//  dig_err    out  1   one-cycle pulse on unrecognised pattern or non-one-hot strobe
//  dig_mask   out  8   digits captured so far in current frame (bit i = digit i)
// BEHAVIOUR
//  Reset: value=0, value_vld=0, dig_err=0, dig_mask=0, FSM=S_WAIT, settle counter=0, digit regs=0.
//  Sampled pair P={enable,segs} (after optional sync); P_prev = P of previous cycle.
//  FSM:
//   S_WAIT  : enable==8'hFF (blank) -> stay. enable one-hot-low -> S_SETTLE, cnt=1.
//             enable with >=2 low bits -> dig_err pulse once per distinct pattern, stay.
//   S_SETTLE: P!=P_prev -> cnt=1 (restart, re-evaluate as in S_WAIT). cnt==STABLE_CNT -> capture, S_HOLD. else cnt++.
//   S_HOLD  : P!=P_prev -> S_WAIT handling applied to new P in the same cycle. No recapture while stable.
//  Capture: decode segs via table; valid -> digit[i]<=nibble, dig_mask[i]<=1. invalid -> dig_err pulse, mask unchanged.
//  Decode table (segs -> nibble): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5 0100000=6
//   0001111=7 0000000=8 0000100=9 0001000=A 1100000=B 0110001=C 1000010=D 0110000=E 0111000=F; all else invalid.
//  Frame: in the cycle dig_mask would become 8'hFF -> value<= all 8 digits (including this capture),
//   value_vld=1 for one cycle, dig_mask<=0. Recapturing an already-set digit overwrites it (latest wins).
//  Latency: strobe change to capture = STABLE_CNT cycles (+2 with sync); capture to value_vld = 1 cycle.
//  Simultaneous: final capture and frame-complete in same cycle as above; err and vld may both pulse only on distinct cycles.
//  Reset mid-frame discards partial digits and mask; value returns to 0.
//  value holds until next complete frame; never partially updated.
// CONFIGURATION
//  SEG_SCAN_SYNC_EN defined : enable and segs pass through a 2-flop synchroniser (reset to 8'hFF / 7'h7F) before the FSM;
//   latency +2 cycles; use when the bus comes from another board/clock.
//  not defined              : inputs sampled directly on clk; caller guarantees same-clock source.
// STRUCTURE
//  Package seg_scan_pkg: FSM state encoding (S_WAIT, S_SETTLE, S_HOLD), 16-entry seg pattern constants,
//   BLANK_EN = 8'hFF.
//  Sub-module seg7_to_hex: combinational segs[6:0] -> {valid, nibble[3:0]}; shared with future display-side checks.
// TESTING
//  1 Scan digit0=0100000 ('6'), digits1..7=0000001 ('0'), each held 8 cycles -> one value_vld, value=32'h0000_0006.
//  2 Scan digits 7..0 of 0xDEAD_BEEF, then again 0x1234_5678 -> vld twice, value 32'hDEADBEEF then 32'h12345678.
//  3 Strobe held STABLE_CNT-1 cycles then changed -> no capture, dig_mask unchanged; held STABLE_CNT -> mask bit set.
//  4 segs=1111111 on digit 3 -> dig_err pulse, dig_mask[3]=0; enable=8'b1111_1100 -> dig_err, no capture.
//  5 Seven digits captured, rst low 1 cycle -> dig_mask=0, value=0; new full frame -> value_vld once.
//  6 Blank (8'hFF) gaps of 3 cycles between digits -> ignored; frame completes normally, no dig_err.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan-bus decoder.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    localparam logic [7:0] BLANK_EN   = 8'hFF;
    localparam logic [6:0] BLANK_SEGS = 7'h7F;

    // Active-low {a,b,c,d,e,f,g} pattern for each hex nibble; entry i decodes to i.
    localparam logic [15:0][6:0] SEG_PAT = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // D
        7'b0110001,  // C
        7'b1100000,  // B
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational active-low 7-segment pattern to hex nibble decoder.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] segs_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        valid_o  = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (segs_i == SEG_PAT[i]) begin
                valid_o  = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for the multiplexed 8-digit 7-segment bus; reassembles the 32-bit word.
// Define SEG_SCAN_SYNC_EN to put a 2-flop synchroniser on enable/segs (adds 2 cycles of latency).
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  enable,
    input  logic [6:0]  segs,
    output logic [31:0] value,
    output logic        value_vld,
    output logic        dig_err,
    output logic [7:0]  dig_mask
);

    // cnt holds how many cycles the pair has been seen; capture on the last one.
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

    logic [7:0] en_p;
    logic [6:0] sg_p;

`ifdef SEG_SCAN_SYNC_EN
    logic [7:0] en_s1_q, en_s2_q;
    logic [6:0] sg_s1_q, sg_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_s1_q <= BLANK_EN;
            en_s2_q <= BLANK_EN;
            sg_s1_q <= BLANK_SEGS;
            sg_s2_q <= BLANK_SEGS;
        end else begin
            en_s1_q <= enable;
            en_s2_q <= en_s1_q;
            sg_s1_q <= segs;
            sg_s2_q <= sg_s1_q;
        end
    end

    assign en_p = en_s2_q;
    assign sg_p = sg_s2_q;
`else
    assign en_p = enable;
    assign sg_p = segs;
`endif

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [14:0] p_prev_q, p_prev_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] value_q, value_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;

    logic        dec_valid;
    logic [3:0]  dec_nibble;
    logic        changed;
    logic        do_eval;
    logic        capture;
    logic [7:0]  mask_nxt;

    seg7_to_hex u_seg7_to_hex (
        .segs_i   (sg_p),
        .valid_o  (dec_valid),
        .nibble_o (dec_nibble)
    );

    assign p_prev_d = {en_p, sg_p};
    assign changed  = (p_prev_d != p_prev_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        mask_d   = mask_q;
        value_d  = value_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        do_eval  = 1'b0;
        capture  = 1'b0;
        mask_nxt = mask_q;

        unique case (state_q)
            S_WAIT: do_eval = 1'b1;
            S_SETTLE: begin
                if (changed) begin
                    do_eval = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLD: do_eval = changed;
            default: state_d = S_WAIT;
        endcase

        // Fresh look at the current pair, shared by S_WAIT and any change seen elsewhere.
        if (do_eval) begin
            if (en_p == BLANK_EN) begin
                state_d = S_WAIT;
            end else if ($onehot(~en_p)) begin
                cnt_d = 8'd1;
                if (STABLE_CNT == 1) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_SETTLE;
                end
            end else begin
                state_d = S_WAIT;
                err_d   = changed;
            end
        end

        if (capture) begin
            if (dec_valid) begin
                for (int i = 0; i < 8; i++) begin
                    if (!en_p[i]) begin
                        digits_d[4*i +: 4] = dec_nibble;
                    end
                end
                mask_nxt = mask_q | ~en_p;
                if (mask_nxt == 8'hFF) begin
                    value_d = digits_d;
                    vld_d   = 1'b1;
                    mask_d  = 8'h00;
                end else begin
                    mask_d = mask_nxt;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_WAIT;
            cnt_q    <= 8'd0;
            p_prev_q <= {BLANK_EN, BLANK_SEGS};
            digits_q <= 32'h0;
            mask_q   <= 8'h00;
            value_q  <= 32'h0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_prev_q <= p_prev_d;
            digits_q <= digits_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign value     = value_q;
    assign value_vld = vld_q;
    assign dig_err   = err_q;
    assign dig_mask  = mask_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: table of scan rows plus hand-written corner sequences.
module tb_seg_scan_decoder;

    localparam int unsigned STABLE_CNT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  enable = 8'hFF;
    logic [6:0]  segs = 7'h7F;
    logic [31:0] value;
    logic        value_vld;
    logic        dig_err;
    logic [7:0]  dig_mask;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_w;
    logic [7:0]  mdl_mask = 8'h00;

    typedef struct {
        logic [7:0]  en;
        logic [6:0]  sg;
        int unsigned hold;
        logic [7:0]  mask;
        int unsigned errs;
        bit          push;
        logic [31:0] val;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .segs      (segs),
        .value     (value),
        .value_vld (value_vld),
        .dig_err   (dig_err),
        .dig_mask  (dig_mask)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic logic [7:0] en_of(input int d);
        logic [7:0] e;
        e = 8'hFF;
        e[d] = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] en, input logic [6:0] sg, input int unsigned n);
        enable = en;
        segs   = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_row(input logic [7:0] en, input logic [6:0] sg, input int unsigned hold,
                           input logic [7:0] mask, input int unsigned errs, input bit push,
                           input logic [31:0] val);
        vec_t v;
        v.en = en; v.sg = sg; v.hold = hold; v.mask = mask;
        v.errs = errs; v.push = push; v.val = val;
        vecs.push_back(v);
    endtask

    // Reference frame model: mask accumulates, a full mask completes the frame and clears.
    task automatic add_digit(input int d, input logic [3:0] nib, input logic [31:0] word);
        logic [7:0] nm;
        bit         p;
        nm = mdl_mask | ~en_of(d);
        p  = 1'b0;
        if (nm == 8'hFF) begin
            nm = 8'h00;
            p  = 1'b1;
        end
        mdl_mask = nm;
        add_row(en_of(d), seg_of(nib), 8, nm, 0, p, word);
    endtask

    // Scoreboard: every value_vld pops the oldest expected frame.
    always @(negedge clk) begin
        if (rst) begin
            if (dig_err) err_cnt++;
            if (value_vld) begin
                vld_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL vld_unexpected: got value %h with no frame expected", value);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("frame_value", value, exp_w);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          e0;

        // Single digit 6 then seven zeros.
        add_digit(0, 4'h6, 32'h0000_0006);
        for (int d = 1; d < 8; d++) add_digit(d, 4'h0, 32'h0000_0006);
        // Two frames scanned high digit first.
        w = 32'hDEAD_BEEF;
        for (int d = 7; d >= 0; d--) add_digit(d, w[4*d +: 4], w);
        w = 32'h1234_5678;
        for (int d = 7; d >= 0; d--) add_digit(d, w[4*d +: 4], w);
        // Unrecognised pattern, then a two-hot strobe.
        add_row(en_of(3), 7'h7F, 8, mdl_mask, 1, 1'b0, 32'h0);
        add_row(8'hFC, seg_of(4'h0), 8, mdl_mask, 1, 1'b0, 32'h0);
        // Blank gaps between digits.
        w = 32'hCAFE_0123;
        for (int d = 0; d < 8; d++) begin
            add_digit(d, w[4*d +: 4], w);
            if (d < 7) add_row(8'hFF, 7'h7F, 3, mdl_mask, 0, 1'b0, 32'h0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_value", value, 32'h0);
        check("rst_value_vld", 32'(value_vld), 32'h0);
        check("rst_dig_err", 32'(dig_err), 32'h0);
        check("rst_dig_mask", 32'(dig_mask), 32'h0);
        rst = 1'b1;

        foreach (vecs[k]) begin
            if (vecs[k].push) exp_q.push_back(vecs[k].val);
            e0 = err_cnt;
            drive(vecs[k].en, vecs[k].sg, vecs[k].hold);
            check($sformatf("row%0d_mask", k), 32'(dig_mask), 32'(vecs[k].mask));
            check($sformatf("row%0d_err", k), 32'(err_cnt - e0), 32'(vecs[k].errs));
        end

        // Hold one cycle short of the threshold, then exactly at it.
        drive(en_of(2), seg_of(4'h5), STABLE_CNT - 1);
        drive(8'hFF, 7'h7F, 2);
        check("short_hold_mask", 32'(dig_mask), 32'h0);
        drive(en_of(2), seg_of(4'h5), STABLE_CNT - 1);
        check("pre_capture_mask", 32'(dig_mask), 32'h0);
        drive(en_of(2), seg_of(4'h5), 1);
        check("capture_mask", 32'(dig_mask), 32'h04);

        // Seven digits, then reset mid-frame.
        for (int d = 0; d < 7; d++) drive(en_of(d), seg_of(4'(d + 1)), 8);
        check("seven_mask", 32'(dig_mask), 32'h7F);
        check("value_hold", value, 32'hCAFE_0123);
        enable = 8'hFF;
        segs   = 7'h7F;
        rst    = 1'b0;
        @(negedge clk);
        check("midrst_mask", 32'(dig_mask), 32'h0);
        check("midrst_value", value, 32'h0);
        check("midrst_vld", 32'(value_vld), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        w = 32'hFEDC_BA98;
        for (int d = 0; d < 8; d++) begin
            if (d == 7) exp_q.push_back(w);
            drive(en_of(d), seg_of(w[4*d +: 4]), 8);
        end
        check("post_rst_value", value, w);
        drive(8'hFF, 7'h7F, 2);

        check("vld_count", 32'(vld_cnt), 32'd5);
        check("err_count", 32'(err_cnt), 32'd2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
